// File: rtl/pixel_pkg.sv
// Shared types for the pixel readout path: pixel/frame types and serializer states.
package pixel_pkg;

  localparam int unsigned PIXEL_W          = 8;
  localparam int unsigned PIXELS_PER_FRAME = 4;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Element 0 is pixel 1, so byte index 0 is streamed first.
  typedef pixel_t [PIXELS_PER_FRAME-1:0] frame_t;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } ser_state_e;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous frame FIFO with separately tracked level; head is read combinationally.
module frame_fifo
  import pixel_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  frame_t                   wr_data,
  output frame_t                   head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  frame_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/pixel_readout_fifo.sv
// Captures one frame per read phase into a frame FIFO and streams it out byte by byte.
// Define PIXEL_READOUT_DROPCNT_EN to add the saturating drop_count output.
module pixel_readout_fifo
  import pixel_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read,
  input  logic [PIXEL_W-1:0]       data1,
  input  logic [PIXEL_W-1:0]       data2,
  input  logic [PIXEL_W-1:0]       data3,
  input  logic [PIXEL_W-1:0]       data4,
  input  logic                     out_ready,
  input  logic                     clear_ovf,
  output logic [PIXEL_W-1:0]       out_data,
  output logic                     out_valid,
  output logic                     out_first,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
`ifdef PIXEL_READOUT_DROPCNT_EN
  output logic [CNT_W-1:0]         drop_count,
`endif
  output logic                     overflow
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic       read_q;
  logic       push;
  logic       handshake;
  logic       pop;
  logic       wr_en;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  frame_t     head;
  frame_t     wr_frame;

  ser_state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       ovf_q, ovf_d;

  assign push      = read & ~read_q;
  assign handshake = out_valid & out_ready;
  assign pop       = handshake & (idx_q == 2'd3);
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign wr_en     = push & (~fifo_full | pop);
  assign drop      = push & fifo_full & ~pop;
  assign wr_frame  = {data4, data3, data2, data1};

  frame_fifo #(
    .DEPTH (DEPTH)
  ) u_frame_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_frame),
    .head    (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty || wr_en) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (fifo_level <= LVL_W'(1) && !wr_en) begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    out_valid = (state_q == SEND);
    out_data  = out_valid ? head[idx_q] : '0;
    out_first = out_valid & (idx_q == 2'd0);
    out_last  = out_valid & (idx_q == 2'd3);
  end

  // A drop in the same cycle as clear_ovf takes precedence.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_q  <= 1'b0;
      state_q <= IDLE;
      idx_q   <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      read_q  <= read;
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;

`ifdef PIXEL_READOUT_DROPCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drop) begin
      if (clear_ovf) begin
        cnt_d = CNT_W'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clear_ovf) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign drop_count = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pixel_readout_fifo.sv
// Directed bench for pixel_readout_fifo; inputs driven and outputs sampled on the falling edge.
module tb_pixel_readout_fifo;

  logic       clk;
  logic       reset;
  logic       read;
  logic [7:0] data1, data2, data3, data4;
  logic       out_ready;
  logic       clear_ovf;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_first;
  logic       out_last;
  logic [2:0] fifo_level;
  logic       overflow;
`ifdef PIXEL_READOUT_DROPCNT_EN
  logic [7:0] drop_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  pixel_readout_fifo #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .read       (read),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .data4      (data4),
    .out_ready  (out_ready),
    .clear_ovf  (clear_ovf),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_first  (out_first),
    .out_last   (out_last),
    .fifo_level (fifo_level),
`ifdef PIXEL_READOUT_DROPCNT_EN
    .drop_count (drop_count),
`endif
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame f carries bytes ((f+1)<<4) + 1 .. + 4, pixel 1 first.
  function automatic logic [7:0] fbyte(input int f, input int j);
    return 8'((f + 1) * 16 + j + 1);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_byte(input string tag, input int f, input int j);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, out_data}, {24'd0, fbyte(f, j)});
    check({tag, "_first"}, {31'd0, out_first}, {31'd0, (j == 0)});
    check({tag, "_last"}, {31'd0, out_last}, {31'd0, (j == 3)});
  endtask

  task automatic set_data(input int f);
    data1 = fbyte(f, 0);
    data2 = fbyte(f, 1);
    data3 = fbyte(f, 2);
    data4 = fbyte(f, 3);
  endtask

  task automatic pulse(input int f);
    set_data(f);
    read = 1'b1;
    cyc();
    read = 1'b0;
    cyc();
  endtask

  initial begin
    int frames [4];
    int cnt;
    int max_lvl;

    reset = 1'b0; read = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    set_data(0);
    cyc(); cyc();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_first", {31'd0, out_first}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    cyc();

    // Single frame, one-cycle latency, 4 consecutive bytes.
    out_ready = 1'b1;
    set_data(0);
    read = 1'b1;
    cyc();
    read = 1'b0;
    check("single_lvl", {29'd0, fifo_level}, 32'd1);
    for (int j = 0; j < 4; j++) begin
      check_byte("single", 0, j);
      cyc();
    end
    check("single_idle", {31'd0, out_valid}, 32'd0);
    check("single_lvl0", {29'd0, fifo_level}, 32'd0);

    // Long read phase yields exactly one frame.
    cnt = 0; max_lvl = 0;
    set_data(9);
    for (int i = 0; i < 14; i++) begin
      read = (i < 10);
      cyc();
      if (out_valid) cnt++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    end
    read = 1'b0;
    check("long_bytes", cnt, 32'd4);
    check("long_maxlvl", max_lvl, 32'd1);

    // Stall on byte 2 for five cycles.
    set_data(1);
    read = 1'b1;
    cyc();
    read = 1'b0;
    check_byte("stall_b0", 1, 0);
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_byte("stall_hold", 1, 1);
      cyc();
    end
    out_ready = 1'b1;
    check_byte("stall_hold_end", 1, 1);
    cyc();
    check_byte("stall_b2", 1, 2);
    cyc();
    check_byte("stall_b3", 1, 3);
    cyc();
    check("stall_idle", {31'd0, out_valid}, 32'd0);

    // Six frames into a stalled 4-deep FIFO: two dropped.
    out_ready = 1'b0;
    for (int f = 0; f < 6; f++) pulse(f);
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
`ifdef PIXEL_READOUT_DROPCNT_EN
    check("ovf_dropcnt", {24'd0, drop_count}, 32'd2);
`endif
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 4; j++) begin
        check_byte("ovf_drain", f, j);
        cyc();
      end
    end
    check("ovf_drain_idle", {31'd0, out_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clear_ovf = 1'b1;
    cyc();
    clear_ovf = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
`ifdef PIXEL_READOUT_DROPCNT_EN
    check("ovf_cnt_cleared", {24'd0, drop_count}, 32'd0);
`endif

    // Full FIFO: push coincides with the head's final handshake.
    out_ready = 1'b0;
    for (int f = 0; f < 4; f++) pulse(f);
    check("full_level", {29'd0, fifo_level}, 32'd4);
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check_byte("full_head", 0, j);
      cyc();
    end
    check_byte("full_head", 0, 3);
    set_data(8);
    read = 1'b1;
    cyc();
    read = 1'b0;
    check("full_level_kept", {29'd0, fifo_level}, 32'd4);
    check("full_no_drop", {31'd0, overflow}, 32'd0);
    frames = '{1, 2, 3, 8};
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        check_byte("full_drain", frames[k], j);
        cyc();
      end
    end
    check("full_drain_idle", {31'd0, out_valid}, 32'd0);

    // Reset during byte 2 of the first of three queued frames.
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) pulse(f);
    out_ready = 1'b1;
    check_byte("mid_b0", 0, 0);
    cyc();
    check_byte("mid_b1", 0, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_first", {31'd0, out_first}, 32'd0);
    check("mid_rst_last", {31'd0, out_last}, 32'd0);
    check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    cyc();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_valid) cnt++;
    end
    check("mid_quiet", cnt, 32'd0);
    set_data(11);
    read = 1'b1;
    cyc();
    read = 1'b0;
    check_byte("mid_new", 11, 0);
    for (int j = 1; j < 4; j++) begin
      cyc();
      check_byte("mid_new", 11, j);
    end
    cyc();

    // read already high at reset release counts as a rising edge.
    reset = 1'b0;
    set_data(12);
    read = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    check_byte("rel_edge", 12, 0);
    cyc();
    check_byte("rel_edge", 12, 1);
    read = 1'b0;
    cyc(); cyc(); cyc();
    check("rel_idle", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
